ram_ctrl: RTL and testbench

- Master-side sequencer for the team's single-port-style scratch RAM (read port sampled on posedge, write committed on negedge, tri-state data_out gated by cs).
- Accepts burst read/write commands over a valid/ready handshake and generates the RAM's read_addr/write_addr/rd_en/wr_en/cs.
- Streams write data in and read data out, with backpressure on both streams.
- Sits between datapath/DMA logic and the RAM instance.

---
 rtl/ram_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_ram_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: burst sequencer for the scratch RAM (posedge read, negedge write).
// Define RAM_CTRL_BOUNDS_EN to reject bursts leaving [0, NUMADDR) via cmd_err.
module ram_ctrl #(
  parameter int WORDSIZE = 16,
  parameter int ADDRSIZE = 5,
  parameter int NUMADDR  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDRSIZE-1:0] cmd_addr,
  input  logic [ADDRSIZE-1:0] cmd_len,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [WORDSIZE-1:0] wdata,
  output logic                rdata_valid,
  input  logic                rdata_ready,
  output logic [WORDSIZE-1:0] rdata,
  output logic                rdata_last,
  output logic                cmd_done,
`ifdef RAM_CTRL_BOUNDS_EN
  output logic                cmd_err,
`endif
  output logic [ADDRSIZE-1:0] ram_read_addr,
  output logic [ADDRSIZE-1:0] ram_write_addr,
  output logic                ram_rd_en,
  output logic                ram_wr_en,
  output logic                ram_cs,
  output logic [WORDSIZE-1:0] ram_data_in,
  input  logic [WORDSIZE-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RD_DRAIN
  } state_e;

  localparam logic [ADDRSIZE-1:0] LAST_ADDR =
    ADDRSIZE'(NUMADDR - 1);
  localparam logic [ADDRSIZE-1:0] ONE = ADDRSIZE'(1);

  state_e state_q, state_d;

  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic [ADDRSIZE-1:0] cnt_q, cnt_d;
  logic [ADDRSIZE-1:0] raddr_q, raddr_d;
  logic [ADDRSIZE-1:0] waddr_q, waddr_d;
  logic [WORDSIZE-1:0] wdat_q, wdat_d;

  logic rd_en_q, rd_en_d;
  logic rd_last_q, rd_last_d;
  logic cap_q, cap_last_q;
  logic wr_en_q, wr_en_d;
  logic cs_q, cs_d;
  logic done_q, done_d;

  logic [WORDSIZE-1:0] fdata_q [2];
  logic [WORDSIZE-1:0] fdata_d [2];
  logic [1:0]          flast_q, flast_d;
  logic                rptr_q, rptr_d;
  logic                wptr_q, wptr_d;
  logic [1:0]          fcnt_q, fcnt_d;

  logic pop, push, room, oob;

  function automatic logic [ADDRSIZE-1:0] incr(
    input logic [ADDRSIZE-1:0] a
  );
    return (a == LAST_ADDR) ? '0 : a + ONE;
  endfunction

`ifdef RAM_CTRL_BOUNDS_EN
  logic              err_q, err_d;
  logic [ADDRSIZE:0] span;

  assign span = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign oob  = span >= (ADDRSIZE+1)'(NUMADDR);
  assign cmd_err = err_q;
`else
  assign oob = 1'b0;
`endif

  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign rdata_valid = (fcnt_q != 2'd0);
  assign rdata       = fdata_q[rptr_q];
  assign rdata_last  = flast_q[rptr_q] & rdata_valid;
  assign cmd_done    = done_q;

  assign ram_read_addr  = raddr_q;
  assign ram_write_addr = waddr_q;
  assign ram_rd_en      = rd_en_q;
  assign ram_wr_en      = wr_en_q;
  assign ram_cs         = cs_q;
  assign ram_data_in    = wdat_q;

  assign pop  = rdata_valid & rdata_ready;
  assign push = cap_q;

  always_comb begin
    fdata_d = fdata_q;
    flast_d = flast_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) begin
      fdata_d[wptr_q] = ram_data_out;
      flast_d[wptr_q] = cap_last_q;
      wptr_d          = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end
    fcnt_d = fcnt_q + 2'(push) - 2'(pop);
  end

  // A new issue lands in the FIFO two edges later; everything
  // ahead of it must leave at most one slot occupied by then.
  assign room = ({1'b0, fcnt_d} + 3'(rd_en_q)) < 3'd2;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdat_d    = wdat_q;
    rd_en_d   = 1'b0;
    rd_last_d = 1'b0;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
`ifdef RAM_CTRL_BOUNDS_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (oob) begin
            done_d = 1'b1;
`ifdef RAM_CTRL_BOUNDS_EN
            err_d  = 1'b1;
`endif
          end else if (cmd_write) begin
            state_d = WRITE;
            addr_d  = cmd_addr;
            cnt_d   = cmd_len;
          end else begin
            rd_en_d   = 1'b1;
            raddr_d   = cmd_addr;
            rd_last_d = (cmd_len == '0);
            addr_d    = incr(cmd_addr);
            cnt_d     = cmd_len - ONE;
            state_d   = (cmd_len == '0) ? RD_DRAIN : READ;
          end
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          wr_en_d = 1'b1;
          waddr_d = addr_q;
          wdat_d  = wdata;
          addr_d  = incr(addr_q);
          cnt_d   = cnt_q - ONE;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (room) begin
          rd_en_d   = 1'b1;
          raddr_d   = addr_q;
          rd_last_d = (cnt_q == '0);
          addr_d    = incr(addr_q);
          cnt_d     = cnt_q - ONE;
          if (cnt_q == '0) begin
            state_d = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (pop && rdata_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    // Keep the RAM selected while a write commits or read data is in flight.
    cs_d = (state_d != IDLE) | rd_en_d | wr_en_d | rd_en_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdat_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_last_q  <= 1'b0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
      wr_en_q    <= 1'b0;
      cs_q       <= 1'b0;
      done_q     <= 1'b0;
      fdata_q    <= '{default: '0};
      flast_q    <= '0;
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
      fcnt_q     <= '0;
`ifdef RAM_CTRL_BOUNDS_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      wdat_q     <= wdat_d;
      rd_en_q    <= rd_en_d;
      rd_last_q  <= rd_last_d;
      cap_q      <= rd_en_q;
      cap_last_q <= rd_last_q;
      wr_en_q    <= wr_en_d;
      cs_q       <= cs_d;
      done_q     <= done_d;
      fdata_q    <= fdata_d;
      flast_q    <= flast_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      fcnt_q     <= fcnt_d;
`ifdef RAM_CTRL_BOUNDS_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed and random bursts against a behavioural RAM and
// a reference memory image; define RAM_CTRL_BOUNDS_EN for the bounds build.
module tb_ram_ctrl;

  localparam int W = 16;
  localparam int A = 5;
`ifdef RAM_CTRL_BOUNDS_EN
  localparam int N = 20;
`else
  localparam int N = 32;
`endif

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [A-1:0] cmd_addr;
  logic [A-1:0] cmd_len;
  logic         wdata_valid;
  logic         wdata_ready;
  logic [W-1:0] wdata;
  logic         rdata_valid;
  logic         rdata_ready;
  logic [W-1:0] rdata;
  logic         rdata_last;
  logic         cmd_done;
`ifdef RAM_CTRL_BOUNDS_EN
  logic         cmd_err;
`endif
  logic [A-1:0] ram_read_addr;
  logic [A-1:0] ram_write_addr;
  logic         ram_rd_en;
  logic         ram_wr_en;
  logic         ram_cs;
  logic [W-1:0] ram_data_in;
  logic [W-1:0] ram_data_out;

  ram_ctrl #(
    .WORDSIZE(W),
    .ADDRSIZE(A),
    .NUMADDR (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .wdata         (wdata),
    .rdata_valid   (rdata_valid),
    .rdata_ready   (rdata_ready),
    .rdata         (rdata),
    .rdata_last    (rdata_last),
    .cmd_done      (cmd_done),
`ifdef RAM_CTRL_BOUNDS_EN
    .cmd_err       (cmd_err),
`endif
    .ram_read_addr (ram_read_addr),
    .ram_write_addr(ram_write_addr),
    .ram_rd_en     (ram_rd_en),
    .ram_wr_en     (ram_wr_en),
    .ram_cs        (ram_cs),
    .ram_data_in   (ram_data_in),
    .ram_data_out  (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratch RAM: read registered on posedge, write on negedge, gated by cs.
  logic [W-1:0] ram [2**A];
  logic [W-1:0] ram_q = '0;
  always @(posedge clk)
    if (ram_cs && ram_rd_en) ram_q <= ram[ram_read_addr];
  always @(negedge clk)
    if (ram_cs && ram_wr_en) ram[ram_write_addr] <= ram_data_in;
  assign ram_data_out = ram_cs ? ram_q : '0;

  logic [W-1:0] refm [N];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_wdata_ready"}, wdata_ready, 0);
    chk({tag, "_rdata_valid"}, rdata_valid, 0);
    chk({tag, "_rdata_last"}, rdata_last, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_cmd_done"}, cmd_done, 0);
    chk({tag, "_rd_en"}, ram_rd_en, 0);
    chk({tag, "_wr_en"}, ram_wr_en, 0);
    chk({tag, "_cs"}, ram_cs, 0);
    chk({tag, "_raddr"}, ram_read_addr, 0);
    chk({tag, "_waddr"}, ram_write_addr, 0);
    chk({tag, "_wdata_out"}, ram_data_in, 0);
  endtask

  // mode: 0 continuous valid, 1 every other cycle, 2 random
  task automatic do_write(input int a, input int len, input int mode,
                          input bit use_seq, input logic [W-1:0] base);
    int           beat = 0;
    int           x    = a;
    int           pa   = 0;
    bit           prev = 1'b0;
    bit           v;
    logic [W-1:0] pd   = '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = A'(a);
    cmd_len   = A'(len);
    #1;
    chk("wr_accept_ready", cmd_ready, 1);
    for (int cyc = 0; cyc < 400 && beat <= len; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = ($urandom_range(0, 1) == 1) || (cyc > 3 * len + 8);
      endcase
      wdata_valid = v;
      wdata       = use_seq ? W'(int'(base) + beat) : W'($urandom);
      #1;
      chk("wr_en", ram_wr_en, prev);
      if (prev) begin
        chk("wr_addr", ram_write_addr, pa);
        chk("wr_data", ram_data_in, pd);
      end
      chk("wr_done_early", cmd_done, 0);
      chk("wr_cmd_ready_low", cmd_ready, 0);
      chk("wr_wdata_ready", wdata_ready, 1);
      chk("wr_cs", ram_cs, 1);
      prev = v;
      if (v) begin
        pa      = x;
        pd      = wdata;
        refm[x] = wdata;
        x       = (x + 1) % N;
        beat++;
      end
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    chk("wr_last_en", ram_wr_en, 1);
    chk("wr_last_addr", ram_write_addr, pa);
    chk("wr_last_data", ram_data_in, pd);
    chk("wr_done", cmd_done, 1);
    chk("wr_idle_ready", cmd_ready, 1);
    chk("wr_idle_wready", wdata_ready, 0);
    chk("wr_beats", beat, len + 1);
  endtask

  // mode: 0 ready held, 1 ready 1,0,0,1 repeating, 2 random
  task automatic do_read(input int a, input int len, input int mode);
    int exp_addr[$];
    int x         = a;
    int issued    = 0;
    int got       = 0;
    int outst     = 0;
    int first_iss = -1;
    int first_val = -1;
    bit fin       = 1'b0;
    bit last_pop  = 1'b0;
    for (int i = 0; i <= len; i++) begin
      exp_addr.push_back(x);
      x = (x + 1) % N;
    end
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_addr    = A'(a);
    cmd_len     = A'(len);
    rdata_ready = 1'b0;
    #1;
    chk("rd_accept_ready", cmd_ready, 1);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      bit rd;
      bit pp;
      @(negedge clk);
      cmd_valid = 1'b0;
      case (mode)
        0:       rdata_ready = 1'b1;
        1:       rdata_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdata_ready = $urandom_range(0, 1) == 1;
      endcase
      #1;
      if (last_pop) begin
        chk("rd_done", cmd_done, 1);
        chk("rd_cs_idle", ram_cs, 0);
        chk("rd_idle_ready", cmd_ready, 1);
        fin = 1'b1;
      end else begin
        chk("rd_done_early", cmd_done, 0);
        chk("rd_cs", ram_cs, 1);
        chk("rd_cmd_ready_low", cmd_ready, 0);
        rd = ram_rd_en;
        pp = rdata_valid && rdata_ready;
        if (rd) begin
          if (first_iss < 0) first_iss = cyc;
          chk("rd_credit", outst < 2, 1);
          chk("rd_overissue", issued <= len, 1);
          if (issued <= len)
            chk("rd_addr", ram_read_addr, exp_addr[issued]);
          issued++;
        end
        if (rdata_valid && first_val < 0) first_val = cyc;
        if (pp) begin
          chk("rd_overrun", got <= len, 1);
          if (got <= len) begin
            chk("rd_data", rdata, refm[exp_addr[got]]);
            chk("rd_last", rdata_last, got == len);
          end
          if (got == len) last_pop = 1'b1;
          got++;
        end
        outst = outst + int'(rd) - int'(pp);
      end
    end
    chk("rd_finished", fin, 1);
    chk("rd_beats", got, len + 1);
    chk("rd_first_issue", first_iss, 0);
    chk("rd_first_valid", first_val, 2);
    rdata_ready = 1'b0;
  endtask

  initial begin
    int a;
    int l;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    rdata_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("reset");

    do_write(0, N - 1, 0, 1'b0, '0);
    do_write(3, 2, 0, 1'b1, 16'hA001);
    do_read(4, 0, 0);
    do_read(3, 2, 2);

`ifndef RAM_CTRL_BOUNDS_EN
    do_read(30, 3, 0);
    do_read(30, 3, 1);
`else
    do_read(16, 3, 0);
    do_read(16, 3, 1);
`endif

    do_write(10, 3, 1, 1'b0, '0);
    do_read(10, 3, 2);

    // Reset while the second beat of a 4-beat read is issuing.
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_addr    = A'(5);
    cmd_len     = A'(3);
    rdata_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_second_issue", ram_rd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("rst_mid");
    do_read(7, 1, 0);

`ifdef RAM_CTRL_BOUNDS_EN
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = A'(18);
    cmd_len   = A'(3);
    #1;
    chk("oob_accept_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("oob_err", cmd_err, 1);
    chk("oob_done", cmd_done, 1);
    chk("oob_rd_en", ram_rd_en, 0);
    chk("oob_cs", ram_cs, 0);
    chk("oob_idle", cmd_ready, 1);
    @(negedge clk);
    #1;
    chk("oob_err_clear", cmd_err, 0);
    chk("oob_done_clear", cmd_done, 0);
    chk("oob_rd_en_after", ram_rd_en, 0);
`endif

    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(0, N - 1);
      l = $urandom_range(0, N - 1 - a);
      if ($urandom_range(0, 1) == 1)
        do_write(a, l, $urandom_range(0, 2), 1'b0, '0);
      else
        do_read(a, l, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
